// File: rtl/puf_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// puf_access_arbiter_pkg : shared states, owner encoding and default widths
// Revision 1.0
// ============================================================================
package puf_access_arbiter_pkg;

  localparam int DEF_CHALLENGE_WIDTH = 32;
  localparam int DEF_RESPONSE_WIDTH  = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_TRIG    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4
  } state_e;

  typedef enum logic {
    OWN_CALB = 1'b0,
    OWN_TEST = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/puf_access_arbiter_done_sync.sv
`default_nettype none
// ============================================================================
// puf_done_sync : 2-flop synchronizer for puf_done with a one-cycle rise pulse
// Revision 1.0
// ============================================================================
module puf_done_sync (
  input  logic clk_1,
  input  logic rst,
  input  logic done_i,
  output logic done_rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_1) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= done_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Only a fresh 0->1 transition counts; a level held high never re-fires.
  assign done_rise_o = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/puf_access_arbiter.sv
`default_nettype none
// ============================================================================
// puf_access_arbiter : round-robin sharing of the PUF core between calb/test
// Revision 1.0
// ============================================================================
module puf_access_arbiter
  import puf_access_arbiter_pkg::*;
#(
  parameter int CHALLENGE_WIDTH = DEF_CHALLENGE_WIDTH,
  parameter int RESPONSE_WIDTH  = DEF_RESPONSE_WIDTH,
  parameter int SETTLE_CYCLES   = 4,
  parameter int TRIG_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk_1,
  input  logic                       rst,
  input  logic                       calb_req,
  input  logic [CHALLENGE_WIDTH-1:0] calb_challenge,
  output logic                       calb_gnt,
  output logic                       calb_valid,
  input  logic                       test_req,
  input  logic [CHALLENGE_WIDTH-1:0] test_challenge,
  output logic                       test_gnt,
  output logic                       test_valid,
  output logic [CHALLENGE_WIDTH-1:0] puf_challenge,
  output logic                       puf_trigger,
  input  logic                       puf_done,
  input  logic [RESPONSE_WIDTH-1:0]  puf_raw_response,
  input  logic                       puf_xor_response,
  output logic [RESPONSE_WIDTH-1:0]  resp_raw,
  output logic                       resp_xor,
  output logic                       resp_err,
  output logic                       busy,
  output logic [7:0]                 timeout_count
);

  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TRIG_LAST    = 8'(TRIG_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                     state_q, state_d;
  owner_e                     owner_q, owner_d;
  owner_e                     last_q, last_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [CHALLENGE_WIDTH-1:0] chal_q, chal_d;
  logic [RESPONSE_WIDTH-1:0]  raw_q, raw_d;
  logic                       xor_q, xor_d;
  logic                       err_q, err_d;
  logic [7:0]                 tocnt_q, tocnt_d;
  logic                       done_rise;

  puf_done_sync u_done_sync (
    .clk_1       (clk_1),
    .rst         (rst),
    .done_i      (puf_done),
    .done_rise_o (done_rise)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    chal_d   = chal_q;
    raw_d    = raw_q;
    xor_d    = xor_q;
    err_d    = err_q;
    tocnt_d  = tocnt_q;
    calb_gnt = 1'b0;
    test_gnt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // calb wins a tie only when test was the last one served
        if (!rst && calb_req && (!test_req || last_q == OWN_TEST)) begin
          calb_gnt = 1'b1;
          owner_d  = OWN_CALB;
          chal_d   = calb_challenge;
          cnt_d    = '0;
          state_d  = ST_SETTLE;
        end else if (!rst && test_req) begin
          test_gnt = 1'b1;
          owner_d  = OWN_TEST;
          chal_d   = test_challenge;
          cnt_d    = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_TRIG;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WAIT: begin
        // Response is sampled on the done edge so it is already on resp_* during CAPTURE.
        if (done_rise) begin
          raw_d   = puf_raw_response;
          xor_d   = puf_xor_response;
          err_d   = 1'b0;
          state_d = ST_CAPTURE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          raw_d   = '0;
          xor_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_CAPTURE;
          if (tocnt_q != 8'hFF) begin
            tocnt_d = tocnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_CAPTURE: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_CALB;
      last_q  <= OWN_TEST;
      cnt_q   <= '0;
      chal_q  <= '0;
      raw_q   <= '0;
      xor_q   <= 1'b0;
      err_q   <= 1'b0;
      tocnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      chal_q  <= chal_d;
      raw_q   <= raw_d;
      xor_q   <= xor_d;
      err_q   <= err_d;
      tocnt_q <= tocnt_d;
    end
  end

  assign puf_challenge = chal_q;
  assign puf_trigger   = (state_q == ST_TRIG);
  assign busy          = (state_q != ST_IDLE);
  assign calb_valid    = ~rst & (state_q == ST_CAPTURE) & (owner_q == OWN_CALB);
  assign test_valid    = ~rst & (state_q == ST_CAPTURE) & (owner_q == OWN_TEST);
  assign resp_raw      = raw_q;
  assign resp_xor      = xor_q;
  assign resp_err      = err_q;
  assign timeout_count = tocnt_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_access_arbiter.sv
`default_nettype none
// ============================================================================
// tb_puf_access_arbiter : scoreboard bench with a transaction-level arbiter model
// Revision 1.0
// ============================================================================
module tb_puf_access_arbiter;

  localparam int CW = 32;
  localparam int RW = 6;
  localparam int S  = 4;
  localparam int T  = 2;
  localparam int TO = 40;

  logic          clk_1 = 1'b0;
  logic          rst = 1'b1;
  logic          calb_req = 1'b0;
  logic          test_req = 1'b0;
  logic [CW-1:0] calb_challenge = '0;
  logic [CW-1:0] test_challenge = '0;
  logic          calb_gnt, calb_valid, test_gnt, test_valid;
  logic [CW-1:0] puf_challenge;
  logic          puf_trigger;
  logic          puf_done = 1'b0;
  logic [RW-1:0] puf_raw_response = '0;
  logic          puf_xor_response = 1'b0;
  logic [RW-1:0] resp_raw;
  logic          resp_xor, resp_err, busy;
  logic [7:0]    timeout_count;

  puf_access_arbiter #(
    .CHALLENGE_WIDTH (CW),
    .RESPONSE_WIDTH  (RW),
    .SETTLE_CYCLES   (S),
    .TRIG_CYCLES     (T),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk_1            (clk_1),
    .rst              (rst),
    .calb_req         (calb_req),
    .calb_challenge   (calb_challenge),
    .calb_gnt         (calb_gnt),
    .calb_valid       (calb_valid),
    .test_req         (test_req),
    .test_challenge   (test_challenge),
    .test_gnt         (test_gnt),
    .test_valid       (test_valid),
    .puf_challenge    (puf_challenge),
    .puf_trigger      (puf_trigger),
    .puf_done         (puf_done),
    .puf_raw_response (puf_raw_response),
    .puf_xor_response (puf_xor_response),
    .resp_raw         (resp_raw),
    .resp_xor         (resp_xor),
    .resp_err         (resp_err),
    .busy             (busy),
    .timeout_count    (timeout_count)
  );

  always #5 clk_1 = ~clk_1;

  int cyc = 0;
  always @(posedge clk_1) cyc <= cyc + 1;

  typedef struct { bit owner; int cyc; } gnt_t;
  typedef struct {
    bit owner; int cyc; logic [CW-1:0] chal; logic [RW-1:0] raw; bit xr; bit err; int tocnt;
  } val_t;
  typedef struct { bit has_done; int d; logic [RW-1:0] raw; bit xr; } job_t;

  gnt_t gnt_q[$];
  val_t val_q[$];
  job_t job_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state
  int free_at  = 0;
  bit m_last   = 1'b1;
  int m_tocnt  = 0;
  int busy_lo  = 1, busy_hi = 0;
  int trig_lo  = 1, trig_hi = 0;
  int job_mode = 0;   // 0: done after nxt_d, 1: random, 2: done never arrives
  int nxt_d    = 3;
  bit granted  = 1'b0;
  bit g_owner  = 1'b0;
  int g_cyc    = 0;
  bit mon_en   = 1'b0;
  bit stale_hi = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arbitrate on the current request levels, then advance one cycle.
  task automatic step();
    granted = 1'b0;
    if (!rst && cyc >= free_at && (calb_req || test_req)) begin
      job_t j;
      val_t v;
      bit   w;
      w = (calb_req && (!test_req || m_last)) ? 1'b0 : 1'b1;
      j.raw = RW'($urandom);
      j.xr  = 1'($urandom);
      case (job_mode)
        0:       begin j.has_done = 1'b1; j.d = nxt_d; end
        1:       begin j.has_done = ($urandom_range(0, 7) != 0); j.d = $urandom_range(1, 6); end
        default: begin j.has_done = 1'b0; j.d = 0; end
      endcase
      v.owner = w;
      v.chal  = w ? test_challenge : calb_challenge;
      // done edge appears at WAIT index d+2; the limit at index TO-1; done wins a tie
      if (j.has_done && (j.d + 2 <= TO - 1)) begin
        v.err = 1'b0; v.raw = j.raw; v.xr = j.xr; v.cyc = cyc + 1 + S + T + j.d + 3;
      end else begin
        v.err = 1'b1; v.raw = '0; v.xr = 1'b0; v.cyc = cyc + 1 + S + T + TO;
        if (m_tocnt < 255) m_tocnt++;
      end
      v.tocnt = m_tocnt;
      gnt_q.push_back('{owner: w, cyc: cyc});
      val_q.push_back(v);
      job_q.push_back(j);
      busy_lo = cyc + 1;     busy_hi = v.cyc;
      trig_lo = cyc + 1 + S; trig_hi = cyc + S + T;
      free_at = v.cyc + 1;
      m_last  = w;
      granted = 1'b1; g_owner = w; g_cyc = cyc;
    end
    @(posedge clk_1);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_grant();
    granted = 1'b0;
    for (int i = 0; i < 2000 && !granted; i++) step();
    if (!granted) check("grant_wait_expired", 1'b0, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && cyc < free_at; i++) step();
  endtask

  task automatic reset_now();
    rst = 1'b1;
    if (val_q.size() > 0 && val_q[$].cyc > cyc) void'(val_q.pop_back());
    job_q.delete();
    if (busy_hi > cyc) busy_hi = cyc;
    if (trig_hi > cyc) trig_hi = cyc;
    free_at = cyc + 1;
    m_last  = 1'b1;
    m_tocnt = 0;
    step();
    rst = 1'b0;
  endtask

  // Behavioural PUF core: answers d cycles after trigger falls.
  initial begin : core_model
    bit   prev_trig;
    bit   active;
    bit   core_done;
    int   tmr;
    job_t j;
    prev_trig = 1'b0; active = 1'b0; core_done = 1'b0; tmr = 0;
    j = '{has_done: 1'b0, d: 0, raw: '0, xr: 1'b0};
    forever begin
      @(negedge clk_1);
      if (rst) begin
        active = 1'b0; tmr = 0; core_done = 1'b0;
      end else begin
        if (puf_trigger && !prev_trig && job_q.size() > 0) begin
          j = job_q.pop_front();
          active = 1'b1; core_done = 1'b0; tmr = 0;
          puf_raw_response = j.raw;
          puf_xor_response = j.xr;
        end
        if (!puf_trigger && prev_trig && active) begin
          if (j.has_done) tmr = j.d;
          active = 1'b0;
        end else if (tmr > 0) begin
          tmr--;
          if (tmr == 0) core_done = 1'b1;
        end
      end
      prev_trig = puf_trigger;
      puf_done  = core_done | stale_hi;
    end
  end

  initial begin : monitor
    gnt_t g;
    val_t e;
    forever begin
      @(negedge clk_1);
      if (mon_en) begin
        check("puf_trigger", puf_trigger, (cyc >= trig_lo && cyc <= trig_hi));
        check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
        if (calb_gnt || test_gnt) begin
          check("gnt_onehot", calb_gnt & test_gnt, 1'b0);
          if (gnt_q.size() == 0) begin
            check("gnt_unexpected", 1'b1, 1'b0);
          end else begin
            g = gnt_q.pop_front();
            check("gnt_owner", test_gnt, g.owner);
            check("gnt_cycle", cyc, g.cyc);
          end
        end
        if (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin
          check("gnt_missing", 1'b0, 1'b1);
          void'(gnt_q.pop_front());
        end
        if (calb_valid || test_valid) begin
          check("valid_onehot", calb_valid & test_valid, 1'b0);
          if (val_q.size() == 0) begin
            check("valid_unexpected", 1'b1, 1'b0);
          end else begin
            e = val_q.pop_front();
            check("valid_owner", test_valid, e.owner);
            check("valid_cycle", cyc, e.cyc);
            check("resp_raw", resp_raw, e.raw);
            check("resp_xor", resp_xor, e.xr);
            check("resp_err", resp_err, e.err);
            check("timeout_count", timeout_count, e.tocnt);
            check("puf_challenge", puf_challenge, e.chal);
          end
        end
        if (val_q.size() > 0 && val_q[0].cyc < cyc) begin
          check("valid_missing", 1'b0, 1'b1);
          void'(val_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    // Reset with a request pending: nothing may leak out
    rst = 1'b1;
    calb_req = 1'b1;
    calb_challenge = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk_1);
    #1;
    check("rst_calb_gnt", calb_gnt, 1'b0);
    check("rst_test_gnt", test_gnt, 1'b0);
    check("rst_calb_valid", calb_valid, 1'b0);
    check("rst_test_valid", test_valid, 1'b0);
    check("rst_puf_challenge", puf_challenge, '0);
    check("rst_puf_trigger", puf_trigger, 1'b0);
    check("rst_resp_raw", resp_raw, '0);
    check("rst_resp_xor", resp_xor, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout_count", timeout_count, '0);
    calb_req = 1'b0;
    rst = 1'b0;
    free_at = cyc;
    mon_en = 1'b1;
    run(3);

    // Single calibration request, done 3 cycles after trigger falls
    job_mode = 0; nxt_d = 3;
    calb_challenge = 32'hA5A5_0001;
    calb_req = 1'b1;
    wait_grant();
    calb_req = 1'b0;
    wait_idle();

    // Done edge on the same cycle as the limit, then one cycle too late
    nxt_d = TO - 3; calb_challenge = $urandom; calb_req = 1'b1;
    wait_grant(); calb_req = 1'b0; wait_idle();
    nxt_d = TO - 2; test_challenge = $urandom; test_req = 1'b1;
    wait_grant(); test_req = 1'b0; wait_idle();
    run(2);

    // Both requesters held: grants alternate
    job_mode = 1;
    calb_challenge = $urandom; test_challenge = $urandom;
    calb_req = 1'b1; test_req = 1'b1;
    n = 0;
    for (int i = 0; i < 3000 && n < 4; i++) begin
      step();
      if (granted) begin
        n++;
        calb_challenge = $urandom;
        test_challenge = $urandom;
      end
    end
    calb_req = 1'b0; test_req = 1'b0;
    wait_idle();

    // Stale high done must not complete the evaluation
    stale_hi = 1'b1;
    run(6);
    job_mode = 2;
    calb_challenge = $urandom; calb_req = 1'b1;
    wait_grant(); calb_req = 1'b0; wait_idle();
    stale_hi = 1'b0;
    run(4);

    // test_req dropped after grant; calb arrives while the core is busy
    job_mode = 1;
    test_challenge = $urandom; test_req = 1'b1;
    wait_grant(); test_req = 1'b0;
    for (int i = 0; i < 50 && cyc < g_cyc + 1 + S + T + 1; i++) step();
    calb_challenge = $urandom; calb_req = 1'b1;
    wait_grant(); calb_req = 1'b0; wait_idle();

    // Reset in the last trigger cycle, then a normal request
    job_mode = 0; nxt_d = 2;
    calb_challenge = $urandom; calb_req = 1'b1;
    wait_grant(); calb_req = 1'b0;
    for (int i = 0; i < 50 && cyc < g_cyc + S + T; i++) step();
    reset_now();
    test_challenge = $urandom; test_req = 1'b1;
    wait_grant(); test_req = 1'b0; wait_idle();

    // Random traffic
    job_mode = 1;
    for (int i = 0; i < 600; i++) begin
      calb_req = ($urandom_range(0, 3) != 0);
      test_req = ($urandom_range(0, 3) != 0);
      calb_challenge = $urandom;
      test_challenge = $urandom;
      step();
    end
    calb_req = 1'b0; test_req = 1'b0;
    wait_idle();

    // Consecutive timeouts saturate the counter
    job_mode = 2;
    calb_req = 1'b1; test_req = 1'b1;
    n = 0;
    for (int i = 0; i < 20000 && n < 256; i++) begin
      step();
      if (granted) begin
        n++;
        calb_challenge = $urandom;
        test_challenge = $urandom;
      end
    end
    calb_req = 1'b0; test_req = 1'b0;
    wait_idle();
    run(3);

    check("gnt_queue_drained", gnt_q.size(), 0);
    check("valid_queue_drained", val_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/puf_access_arbiter.md
Name: puf_access_arbiter

Overview:
- Shares the single PUF mapping core between two requesters: the PC calibration path (calb) and the on-chip test sequencer (test).
- For each granted request it sequences one full evaluation: drive challenge, settle, pulse trigger, wait for done, capture response.
- Replaces the static calibrate-mode mux on the challenge and trigger lines with round-robin access and an explicit req/valid handshake.
- Sits between the requesters and the mapping core, all in the clk_1 domain.

Parameters:
- CHALLENGE_WIDTH, 32, PUF challenge width.
- RESPONSE_WIDTH, 6, raw response width.
- SETTLE_CYCLES, 4, cycles the challenge is held stable before trigger rises (valid range 1..15).
- TRIG_CYCLES, 2, trigger high time in cycles (valid range 1..15).
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before abort (valid range 1..255).

Ports:
- clk_1  in  1  system clock
- rst  in  1  reset
- calb_req  in  1  calibration request (level)
- calb_challenge  in  CHALLENGE_WIDTH  calibration challenge, sampled at grant
- calb_gnt  out  1  one-cycle pulse: calibration request accepted
- calb_valid  out  1  one-cycle pulse: calibration result on resp_*
- test_req  in  1  test request (level)
- test_challenge  in  CHALLENGE_WIDTH  test challenge, sampled at grant
- test_gnt  out  1  one-cycle pulse: test request accepted
- test_valid  out  1  one-cycle pulse: test result on resp_*
- puf_challenge  out  CHALLENGE_WIDTH  to mapping core
- puf_trigger  out  1  to mapping core
- puf_done  in  1  from mapping core (asynchronous to clk_1)
- puf_raw_response  in  RESPONSE_WIDTH  from mapping core
- puf_xor_response  in  1  from mapping core
- resp_raw  out  RESPONSE_WIDTH  captured raw response
- resp_xor  out  1  captured xor response
- resp_err  out  1  qualifies *_valid: result aborted by timeout
- busy  out  1  high in any state other than IDLE
- timeout_count  out  8  saturating count of timeouts since reset

Behaviour:
- Reset: rst is synchronous, active-high; clock clk_1.
  - On reset, all outputs go to 0 (puf_challenge, resp_*, timeout_count included).
  - State goes to IDLE; last_served is set to test, so calb wins the first tie.
  - rst asserted mid-operation aborts in one cycle: trigger low, no valid pulse.
- puf_done passes through a 2-flop synchronizer (done_s). WAIT acts only on a 0->1 edge of done_s; a stale high done is ignored.
- FSM states: IDLE, SETTLE, TRIG, WAIT, CAPTURE.
  - IDLE:
    - Arbitrate among requesters with req high.
    - If both request, grant the one not equal to last_served.
    - On grant: pulse *_gnt this cycle, latch the winner's challenge into puf_challenge, record owner, clear the counter, go to SETTLE.
  - SETTLE: puf_trigger=0. After SETTLE_CYCLES cycles, go to TRIG.
  - TRIG: puf_trigger=1 for exactly TRIG_CYCLES cycles, then go to WAIT.
  - WAIT:
    - puf_trigger=0; counter increments each cycle.
    - On a done_s rising edge, go to CAPTURE with err=0.
    - If the counter reaches TIMEOUT_CYCLES first, go to CAPTURE with err=1 and increment timeout_count (saturates at 255).
    - If the done edge and the limit fall in the same cycle, done wins.
  - CAPTURE:
    - Register resp_raw/resp_xor from the core; on err, register 0 instead.
    - Drive resp_err; pulse the owner's *_valid for one cycle.
    - Set last_served=owner; go to IDLE.
- resp_* hold their value until the next CAPTURE.
- puf_challenge holds its value from grant until the next grant.
- Latency from the grant cycle to the valid pulse (done edge arriving k cycles after trigger falls): 1 + SETTLE_CYCLES + TRIG_CYCLES + k + 1 cycles, where k includes the 2 synchronizer cycles.
- A request dropped after grant still completes and still gets its valid pulse.
- req is ignored while busy; a requester holding req high is re-arbitrated in IDLE on the cycle after CAPTURE.
- Back-to-back grants are alternated by round-robin when both requesters hold req.

Decomposition:
- Shared package holds:
  - state enum (IDLE=0, SETTLE=1, TRIG=2, WAIT=3, CAPTURE=4);
  - owner encoding (CALB=0, TEST=1);
  - default widths CHALLENGE_WIDTH/RESPONSE_WIDTH.
- One natural sub-module: puf_done_sync, a 2-flop synchronizer plus rising-edge detect that outputs a one-cycle done_rise.

Test Plan:
- Single calb_req with calb_challenge=32'hA5A5_0001, done rising 3 cycles after trigger falls -> calb_gnt at cycle 0; puf_trigger high at cycles 5-6; calb_valid at cycle 13 carrying the core response; resp_err=0; test_valid never pulses.
- calb_req and test_req both held high -> grant order calb, test, calb, test; each *_valid pulse goes only to its own owner.
- puf_done held high before the request and never toggled -> no early CAPTURE; after 255 WAIT cycles the owner's valid pulses with resp_err=1, resp_raw=0, timeout_count=1.
- 256 consecutive timeouts -> timeout_count saturates at 255.
- rst asserted during TRIG -> next cycle puf_trigger=0, busy=0, state IDLE, no valid pulse; the next request is served normally.
- test_req dropped the cycle after test_gnt -> operation completes and test_valid still pulses; a calb_req arriving during WAIT is granted only after CAPTURE.
